alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// It keeps one operation in flight and returns a registered, flag-masked response.
module alu_arbiter #(
  parameter int unsigned OP_MAX = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_y,
  input  logic        alu_carry,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_y,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [15:0] done0_cnt,
  output logic [15:0] done1_cnt
);

  // state | meaning
  // IDLE  | waiting for a requester, ready offered to the granted one
  // EXEC  | operand register drives the ALU, result captured this cycle
  // RESP  | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        rr_last;
  logic        gnt_id;
  logic        accept;
  logic [31:0] opr_a;
  logic [31:0] opr_b;
  logic [3:0]  opr_op;
  logic        opr_id;
  logic        op_err;
  logic        carry_m;
  logic        ovf_m;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_id = ~req0_valid;
    if (req0_valid && req1_valid) gnt_id = ~rr_last;
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !gnt_id;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && gnt_id;
  assign accept     = req0_ready || req1_ready;

  assign alu_a       = opr_a;
  assign alu_b       = opr_b;
  assign alu_control = opr_op;
  assign rsp_id      = opr_id;

  assign op_err  = 32'(opr_op) > OP_MAX;
  assign carry_m = alu_carry && ((opr_op == 4'd6) || (opr_op == 4'd7));
  assign ovf_m   = alu_overflow && (opr_op == 4'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      opr_a     <= '0;
      opr_b     <= '0;
      opr_op    <= '0;
      opr_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opr_a   <= gnt_id ? req1_a  : req0_a;
            opr_b   <= gnt_id ? req1_b  : req0_b;
            opr_op  <= gnt_id ? req1_op : req0_op;
            opr_id  <= gnt_id;
            rr_last <= gnt_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (op_err) begin
            rsp_y     <= '0;
            rsp_flags <= 4'b0010;
            rsp_err   <= 1'b1;
          end else begin
            rsp_y     <= alu_y;
            rsp_flags <= {carry_m, alu_neg, alu_zero, ovf_m};
            rsp_err   <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (!opr_id && (done0_cnt != 16'hFFFF)) done0_cnt <= done0_cnt + 16'd1;
            if (opr_id && (done1_cnt != 16'hFFFF))  done1_cnt <= done1_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU (op 6 add, op 7 sub,
// 0 and, 1 or, others xor) that deliberately raises carry/overflow on logic ops.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_control;
  logic        alu_carry, alu_neg, alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_flags;
  logic [15:0] done0_cnt, done1_cnt;
  logic [32:0] s33;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.OP_MAX(12)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  always_comb begin
    s33          = '0;
    alu_y        = '0;
    alu_carry    = 1'b1;
    alu_overflow = 1'b1;
    case (alu_control)
      4'd6: begin
        s33          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y        = s33[31:0];
        alu_carry    = s33[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd7: begin
        s33          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_y        = s33[31:0];
        alu_carry    = s33[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd0:    alu_y = alu_a & alu_b;
      4'd1:    alu_y = alu_a | alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
    alu_neg  = alu_y[31];
    alu_zero = (alu_y == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    step(); step();
    check("rst_ready0", req0_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_done0", done0_cnt, 0);
    check("rst_done1", done1_cnt, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_y", rsp_y, 0);

    // add 5+3 from requester 0
    rst = 1'b0; rsp_ready = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'd6;
    #1;
    check("add_ready0", req0_ready, 1);
    check("add_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check("add_exec_rsp_valid", rsp_valid, 0);
    check("add_alu_a", alu_a, 5);
    check("add_alu_ctl", alu_control, 6);
    step();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_y", rsp_y, 8);
    check("add_rsp_flags", rsp_flags, 4'b0000);
    check("add_rsp_id", rsp_id, 0);
    check("add_rsp_err", rsp_err, 0);
    step();
    check("add_done_valid", rsp_valid, 0);
    check("add_done0", done0_cnt, 1);
    check("add_done1", done1_cnt, 0);

    // round robin from a fresh reset, both requesters always valid, AND op
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_a = 32'hF0F0_0000; req0_b = 32'hFF00_0000; req0_op = 4'd0;
    req1_a = 32'h0000_1234; req1_b = 32'h0000_00FF; req1_op = 4'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        step();
        n++;
      end
      check("rr_grant", req1_ready, k % 2);
      check("rr_one_hot", req0_ready & req1_ready, 0);
      step();
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      step();
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, k % 2);
      check("rr_rsp_y", rsp_y, (k % 2) ? 32'h0000_0034 : 32'hF000_0000);
      check("rr_rsp_flags", rsp_flags, (k % 2) ? 4'b0000 : 4'b0100);
      step();
    end
    check("rr_done0", done0_cnt, 2);
    check("rr_done1", done1_cnt, 2);

    // signed overflow on subtract from requester 1
    req1_a = 32'h8000_0000; req1_b = 32'd1; req1_op = 4'd7; req1_valid = 1'b1;
    #1;
    check("sub_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    check("sub_rsp_y", rsp_y, 32'h7FFF_FFFF);
    check("sub_rsp_flags", rsp_flags, 4'b1001);
    check("sub_rsp_id", rsp_id, 1);
    step();
    check("sub_done1", done1_cnt, 3);

    // back-pressure: OR from req0 held 5 cycles, req1 queued with op 13
    rsp_ready = 1'b0;
    req0_a = 32'h0000_00F0; req0_b = 32'h0000_0F00; req0_op = 4'd1;
    req1_a = 32'd7; req1_b = 32'd9; req1_op = 4'd13;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("bp_tie_ready0", req0_ready, 1);
    step();
    req0_a = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_y", rsp_y, 32'h0000_0FF0);
      check("bp_rsp_flags", rsp_flags, 4'b0000);
      check("bp_ready_low", {req0_ready, req1_ready}, 0);
      check("bp_alu_a", alu_a, 32'h0000_00F0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_done0", done0_cnt, 3);
    check("bp_resume_ready1", req1_ready, 1);
    check("bp_resume_ready0", req0_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_y", rsp_y, 0);
    check("err_rsp_flags", rsp_flags, 4'b0010);
    check("err_rsp_id", rsp_id, 1);
    step();
    check("err_done1", done1_cnt, 4);

    // op 12 is the highest legal code: xor to zero, masked carry/overflow
    req0_a = 32'hFF; req0_b = 32'hFF; req0_op = 4'd12; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    check("max_rsp_err", rsp_err, 0);
    check("max_rsp_flags", rsp_flags, 4'b0010);
    check("max_rsp_y", rsp_y, 0);
    step();
    check("max_done0", done0_cnt, 4);

    // reset while in EXEC discards the transaction
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd6; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("xrst_rsp_valid", rsp_valid, 0);
    check("xrst_alu_a", alu_a, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("xrst_no_rsp", rsp_valid, 0);
    end
    check("xrst_done0", done0_cnt, 0);
    check("xrst_done1", done1_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
